// File: rtl/instr_mem_arbiter.sv
// Instruction-memory arbiter: boot loader owns memory in BOOT, fetch has priority in RUN with a starvation override.
// Grants are combinational; read data returns one cycle after fetchGrant. IMEM_WRITE_PROTECT_EN blocks RUN-state loader writes.
module instr_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        fetchReq,
    input  logic [63:0] fetchAddress,
    output logic        fetchGrant,
    output logic        fetchValid,
    output logic [31:0] fetchInstruction,
    input  logic        loadReq,
    input  logic [63:0] loadAddress,
    input  logic [31:0] loadData,
    output logic        loadGrant,
    input  logic        loadDone,
    output logic        loadError,
    output logic        bootComplete,
    output logic [63:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWriteEnable,
    output logic        memReadEnable,
    input  logic [31:0] memReadData
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        fetch_vld_q;
    logic [31:0] instr_hold_q;
    logic        load_err_q, load_err_d;
    logic        load_aligned;
`ifndef IMEM_WRITE_PROTECT_EN
    logic [3:0]  starve_q, starve_d;
    logic        override;
`endif

    assign load_aligned = (loadAddress[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        fetchGrant = 1'b0;
        loadGrant  = 1'b0;
        load_err_d = load_err_q;
`ifndef IMEM_WRITE_PROTECT_EN
        starve_d   = 4'd0;
        override   = 1'b0;
`endif
        unique case (state_q)
            BOOT: begin
                loadGrant = loadReq && load_aligned;
                if (loadDone) state_d = RUN;
            end
            RUN: begin
`ifdef IMEM_WRITE_PROTECT_EN
                fetchGrant = fetchReq;
                if (loadReq) load_err_d = 1'b1;
`else
                // Misaligned requests are consumed, so only aligned denials age the counter.
                override   = loadReq && load_aligned && (starve_q == STARVE_LIMIT[3:0]);
                fetchGrant = fetchReq && !override;
                loadGrant  = loadReq && load_aligned && (!fetchReq || override);
                if (loadReq && load_aligned && !loadGrant) starve_d = starve_q + 4'd1;
`endif
            end
            default: state_d = BOOT;
        endcase
        if (loadReq && !load_aligned) load_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= BOOT;
            fetch_vld_q  <= 1'b0;
            instr_hold_q <= NOP_INSTR;
            load_err_q   <= 1'b0;
`ifndef IMEM_WRITE_PROTECT_EN
            starve_q     <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_vld_q <= fetchGrant;
            load_err_q  <= load_err_d;
            if (fetch_vld_q) instr_hold_q <= memReadData;
`ifndef IMEM_WRITE_PROTECT_EN
            starve_q    <= starve_d;
`endif
        end
    end

    // The memory's own output register supplies the valid-cycle word; instr_hold_q keeps it afterwards.
    assign fetchValid       = fetch_vld_q;
    assign fetchInstruction = fetch_vld_q ? memReadData : instr_hold_q;
    assign loadError        = load_err_q;
    assign bootComplete     = (state_q == RUN);

    assign memAddress     = loadGrant  ? loadAddress :
                            fetchGrant ? fetchAddress : 64'd0;
    assign memWriteData   = loadGrant ? loadData : 32'd0;
    assign memWriteEnable = loadGrant;
    assign memReadEnable  = fetchGrant;

endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive RUN-state cycles a pending loader request may be denied before it is forced a grant (range 1-15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 fetchReq  input  1  fetch stage requests an instruction read.
REQ-005 fetchAddress  input  64  byte address of the instruction.
REQ-006 fetchGrant  output  1  combinational; fetch request accepted this cycle.
REQ-007 fetchValid  output  1  registered; fetchInstruction valid this cycle.
REQ-008 fetchInstruction  output  32  registered; instruction returned for the granted read.
REQ-009 loadReq  input  1  loader requests one word write.
REQ-010 loadAddress  input  64  byte address of the word to write.
REQ-011 loadData  input  32  word to write.
REQ-012 loadGrant  output  1  combinational; write performed this cycle.
REQ-013 loadDone  input  1  single-cycle pulse: loader finished the boot image.
REQ-014 loadError  output  1  registered, sticky; a write was rejected.
REQ-015 bootComplete  output  1  registered; high in RUN state.
REQ-016 memAddress  output  64  combinational memory address, from the granted requester, else 0.
REQ-017 memWriteData  output  32  combinational; loadData when loadGrant, else 0.
REQ-018 memWriteEnable  output  1  equals loadGrant.
REQ-019 memReadEnable  output  1  equals fetchGrant.
REQ-020 memReadData  input  32  synchronous memory read data, valid one cycle after memReadEnable.

Function
REQ-021 States: BOOT, RUN; BOOT -> RUN on the cycle after loadDone is sampled high in BOOT; RUN has no exit other than reset.
REQ-022 BOOT: fetchGrant held 0; loadGrant = loadReq and loadAddress[1:0]==0.
REQ-023 RUN: fetch has priority; fetchGrant = fetchReq unless the starvation override (REQ-025) is active.
REQ-024 RUN: loadGrant = loadReq and not fetchReq, or loadReq and override active; fetchGrant and loadGrant are never both 1.
REQ-025 Starvation counter (4-bit): increments each RUN cycle with loadReq high and loadGrant low; clears on loadGrant or loadReq low; override active when counter == STARVE_LIMIT.
REQ-026 Override cycle: loadGrant=1, fetchGrant=0; fetch stage must hold fetchReq/fetchAddress until granted.
REQ-027 Read latency: fetchValid=1 and fetchInstruction=memReadData exactly one cycle after fetchGrant; back-to-back grants give back-to-back valids.
REQ-028 fetchInstruction holds its last value when fetchValid is 0.
REQ-029 Misaligned loader write (loadAddress[1:0]!=0): never granted, memory untouched; sets loadError the next cycle; the request is consumed (not retried internally).
REQ-030 loadDone asserted together with a granted write: the write completes, transition still occurs.
REQ-031 loadDone in RUN: ignored.

Reset
REQ-032 On resetN low, asynchronously: state=BOOT, fetchValid=0, fetchInstruction=32'h00000013 (NOP), loadError=0, bootComplete=0, starvation counter=0.
REQ-033 Reset mid-read: the pending fetchValid is dropped; no valid is emitted after reset release.
REQ-034 Combinational outputs during reset follow BOOT-state rules from the current inputs.

Configuration
REQ-035 Macro IMEM_WRITE_PROTECT_EN: when defined, loader writes in RUN are never granted and each such loadReq cycle sets loadError; starvation counter stays 0.
REQ-036 Without IMEM_WRITE_PROTECT_EN: RUN-state loader writes are arbitrated per REQ-024/REQ-025.

Verification
REQ-037 Reset; loadReq with addresses 0x0, 0x4, 0x8 and data 0x00500093, 0x00100113, 0x002081B3 in BOOT, fetchReq high -> three loadGrants, fetchGrant stays 0.
REQ-038 loadDone pulse; next cycle -> bootComplete=1; fetchReq address 0x4 -> fetchGrant same cycle, fetchValid and fetchInstruction=0x00100113 one cycle later.
REQ-039 RUN, fetchReq continuous, loadReq continuous, STARVE_LIMIT=4 (macro undefined) -> four fetch grants, then one loadGrant, pattern repeats.
REQ-040 BOOT, loadReq address 0x6 -> no loadGrant, memWriteEnable 0, loadError=1 next cycle and stays 1.
REQ-041 IMEM_WRITE_PROTECT_EN defined, RUN, loadReq with fetchReq low -> loadGrant 0, loadError=1.
REQ-042 resetN pulsed low the cycle after a fetchGrant -> fetchValid 0, fetchInstruction=0x00000013, state BOOT.
